// File: rtl/nvt_trim_pkg.sv
// -----------------------------------------------------------------------------
// nvt_trim_pkg
// Shared definitions for the 5-bit successive-approximation trim engine:
// the trim code width, the MSB trial code that every search starts from,
// the FSM state encoding and a helper that flags a rail result.
// -----------------------------------------------------------------------------
package nvt_trim_pkg;

    localparam int TRIM_W = 5;

    // First trial code of every search: only the MSB set.
    localparam logic [TRIM_W-1:0] MSB_TRIAL = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_DONE
    } state_t;

    // A result at either end of the code range means the search ran out of
    // adjustment range rather than finding a crossing point.
    function automatic logic is_rail(input logic [TRIM_W-1:0] code);
        return (code == '0) || (code == '1);
    endfunction

endpackage

// File: rtl/nvt_sv_sync2.sv
// -----------------------------------------------------------------------------
// nvt_sv_sync2
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk   - destination clock
//   rst_n - synchronous active-low reset, clears both flops to 0
//   d     - asynchronous input level
//   q     - synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module nvt_sv_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample their inputs from the same edge; blocking here would collapse
    // the chain into a single flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nvt_sv_trim_sar.sv
// -----------------------------------------------------------------------------
// nvt_sv_trim_sar
// Successive-approximation search for a 5-bit divider trim code. Each trial
// bit is set, the divider is given SETTLE_CYC cycles to settle, and the
// synchronized comparator decides whether the bit stays.
// Ports:
//   clk        - block clock
//   rst_n      - synchronous active-low reset
//   start      - level request to begin a search (sampled in IDLE only)
//   abort      - cancels a search in progress, wins over start
//   cmp_out    - asynchronous comparator decision
//   trim       - trim code driven to the divider
//   busy       - high while a search is in progress
//   done       - one-cycle pulse when a search completes
//   trim_valid - trim holds a completed search result
//   sat        - completed result sits at a rail (all zeros or all ones)
// -----------------------------------------------------------------------------
module nvt_sv_trim_sar
    import nvt_trim_pkg::*;
#(
    parameter int                SETTLE_CYC = 16,
    parameter logic [TRIM_W-1:0] DEF_TRIM   = 5'b10000,
    parameter logic              CMP_KEEP   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cmp_out,
    output logic [TRIM_W-1:0] trim,
    output logic              busy,
    output logic              done,
    output logic              trim_valid,
    output logic              sat
);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        cnt;
    logic [2:0]        bit_idx;
    logic              cmp_s;
    logic [TRIM_W-1:0] decided;
    logic [TRIM_W-1:0] next_trial;

    nvt_sv_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_out),
        .q     (cmp_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start && !abort) state_nxt = ST_SETTLE;
            // Counter is loaded with SETTLE_CYC and hits 0 on the edge that
            // leaves SETTLE, so the state lasts exactly SETTLE_CYC cycles.
            ST_SETTLE: if (abort)             state_nxt = ST_IDLE;
                       else if (cnt == 8'd1)  state_nxt = ST_DECIDE;
            ST_DECIDE: if (abort)               state_nxt = ST_IDLE;
                       else if (bit_idx == '0)  state_nxt = ST_DONE;
                       else                     state_nxt = ST_SETTLE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == ST_SETTLE) || (state == ST_DECIDE);
        done = (state == ST_DONE);
    end

    // Trial-bit decision for the current bit, and the code with the next
    // lower bit set for the following trial.
    always_comb begin
        decided = trim;
        if (cmp_s != CMP_KEEP) decided[bit_idx] = 1'b0;
        next_trial = decided;
        if (bit_idx != '0) next_trial[3'(bit_idx - 3'd1)] = 1'b1;
    end

    // Search datapath: trim code, settle counter, bit index, result flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trim       <= DEF_TRIM;
            cnt        <= '0;
            bit_idx    <= '0;
            trim_valid <= 1'b0;
            sat        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        trim       <= MSB_TRIAL;
                        bit_idx    <= 3'(TRIM_W - 1);
                        cnt        <= 8'(SETTLE_CYC);
                        trim_valid <= 1'b0;
                        sat        <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        trim       <= DEF_TRIM;
                        trim_valid <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_DECIDE: begin
                    if (abort) begin
                        trim       <= DEF_TRIM;
                        trim_valid <= 1'b0;
                    end else if (bit_idx != '0) begin
                        trim    <= next_trial;
                        bit_idx <= bit_idx - 3'd1;
                        cnt     <= 8'(SETTLE_CYC);
                    end else begin
                        trim       <= decided;
                        trim_valid <= 1'b1;
                        sat        <= is_rail(decided);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nvt_sv_trim_sar.sv
// -----------------------------------------------------------------------------
// tb_nvt_sv_trim_sar
// Self-checking bench for nvt_sv_trim_sar with SETTLE_CYC=4. The comparator
// is modelled as cmp_out = (trim <= target), or forced high/low. Expected
// codes come from a plain greedy bit-by-bit search over the code value.
// -----------------------------------------------------------------------------
module tb_nvt_sv_trim_sar;

    localparam int SETTLE  = 4;
    localparam int LATENCY = 5 * (SETTLE + 1) + 1;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, cmp_out;
    logic [4:0] trim;
    logic       busy, done, trim_valid, sat;

    int cmp_mode;  // 0: compare against target, 1: forced high, 2: forced low
    int target;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (cmp_mode)
            1:       cmp_out = 1'b1;
            2:       cmp_out = 1'b0;
            default: cmp_out = (int'(trim) <= target);
        endcase
    end

    nvt_sv_trim_sar #(
        .SETTLE_CYC (SETTLE),
        .DEF_TRIM   (5'b10000),
        .CMP_KEEP   (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cmp_out    (cmp_out),
        .trim       (trim),
        .busy       (busy),
        .done       (done),
        .trim_valid (trim_valid),
        .sat        (sat)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Greedy search: try each bit from the top, keep it if the comparator
    // (as the bench models it) says the code is still acceptable.
    function automatic int sar_model(input int mode, input int tgt);
        int code = 0;
        for (int b = 4; b >= 0; b--) begin
            int  trial = code | (1 << b);
            bit  keep  = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (trial <= tgt);
            if (keep) code = trial;
        end
        return code;
    endfunction

    // Start a search from IDLE and check completion time and result.
    // repulse_at > 0 pulses start again at that cycle while busy.
    task automatic run_search(input string tag, input int repulse_at);
        int cyc = 0;
        int exp_code = sar_model(cmp_mode, target);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy_at_start"}, int'(busy), 1);
        check({tag, "_trim_msb"}, int'(trim), 16);
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = (cyc == repulse_at);
            if (done) break;
        end
        start = 1'b0;
        check({tag, "_latency"}, cyc, LATENCY);
        check({tag, "_code"}, int'(trim), exp_code);
        check({tag, "_sat"}, int'(sat), int'(exp_code == 0 || exp_code == 31));
        check({tag, "_valid"}, int'(trim_valid), 1);
        check({tag, "_busy_done"}, int'(busy), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_hold"}, int'(trim), exp_code);
    endtask

    // Count done pulses over a window of cycles.
    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int n_done;
        int cyc;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cmp_mode = 0; target = 13;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_trim", int'(trim), 16);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(trim_valid), 0);
        check("rst_sat", int'(sat), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal target and both rails
        target = 13;  run_search("t13", 0);
        check("t13_exact", int'(trim), 13);
        cmp_mode = 1; run_search("force1", 0);
        check("force1_exact", int'(trim), 31);
        cmp_mode = 2; run_search("force0", 0);
        check("force0_exact", int'(trim), 0);
        cmp_mode = 0;

        // Abort during the third SETTLE (bit 2 trial)
        target = 21;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort_trim", int'(trim), 16);
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(trim_valid), 0);
        @(negedge clk);
        abort = 1'b0;
        count_done(40, n_done);
        check("abort_no_done", n_done, 0);
        check("abort_idle_hold", int'(trim), 16);

        // start and abort together in IDLE: no search
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        check("start_abort_busy", int'(busy), 0);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        count_done(10, n_done);
        check("start_abort_no_done", n_done, 0);

        // start re-pulsed while busy: completion time unchanged
        target = 20; run_search("repulse", 8);

        // Reset in the middle of a search
        target = 9;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_trim", int'(trim), 16);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_valid", int'(trim_valid), 0);
        check("mid_rst_sat", int'(sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(40, n_done);
        check("mid_rst_no_done", n_done, 0);
        run_search("after_rst", 0);

        // start held high: retrigger from IDLE one cycle after DONE
        target = 6;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
        check("hold_latency", cyc, LATENCY);
        check("hold_code", int'(trim), 6);
        @(negedge clk);
        check("hold_idle_gap", int'(busy), 0);
        @(negedge clk);
        check("hold_retrigger", int'(busy), 1);
        check("hold_valid_cleared", int'(trim_valid), 0);
        start = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            if (done) break;
            @(negedge clk);
            cyc++;
        end
        check("hold_latency2", cyc, LATENCY);
        check("hold_code2", int'(trim), 6);

        // Randomized targets, including values beyond the code range
        for (int k = 0; k < 10; k++) begin
            target = int'($urandom_range(0, 40));
            run_search($sformatf("rand%0d_t%0d", k, target), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nvt_sv_trim_sar.md
NVT_SV_TRIM_SAR -- requirements
Module: nvt_sv_trim_sar

Interface
REQ-001 Parameter SETTLE_CYC, default 16: clock cycles waited after each trim change before the comparator is sampled (range 1..255).
REQ-002 Parameter DEF_TRIM, default 5'b10000: trim code driven after reset and after abort.
REQ-003 Parameter CMP_KEEP, default 1: comparator level meaning "keep the trial bit". The default applies because setting a trim bit lowers the divider output.
REQ-004 Port clk, input, 1: block clock; one clock domain only.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port start, input, 1: level-sampled request to begin a trim search.
REQ-007 Port abort, input, 1: cancels a search in progress.
REQ-008 Port cmp_out, input, 1: asynchronous comparator decision, driven by the divider output versus its reference.
REQ-009 Port trim, output, 5: trim code delivered to the divider.
REQ-010 Port busy, output, 1: high while a search is in progress.
REQ-011 Port done, output, 1: one-cycle pulse when a search completes.
REQ-012 Port trim_valid, output, 1: high while trim holds a completed search result.
REQ-013 Port sat, output, 1: high when the completed result is 5'b00000 or 5'b11111, meaning the search ran to a rail.

Function
REQ-014 cmp_out SHALL pass through a two-flop synchronizer; every decision SHALL use only the synchronized value.
REQ-015 The FSM SHALL have exactly four states: IDLE, SETTLE, DECIDE, DONE.
REQ-016 In IDLE, start=1 and abort=0 at an edge SHALL load trim=5'b10000, set bit_idx=4, load the settle counter with SETTLE_CYC, set busy=1, clear trim_valid and sat, and go to SETTLE.
REQ-017 SETTLE SHALL decrement the counter each cycle and go to DECIDE on the cycle the counter reaches 0; SETTLE SHALL last exactly SETTLE_CYC cycles.
REQ-018 DECIDE SHALL last one cycle and act on the trial bit trim[bit_idx]:
- synchronized cmp == CMP_KEEP: keep the bit;
- otherwise: clear the bit.
REQ-019 After the REQ-018 decision, when bit_idx>0, the block SHALL decrement bit_idx, set the next lower trim bit, reload the counter and go to SETTLE; when bit_idx==0 it SHALL go to DONE.
REQ-020 DONE SHALL last one cycle: done=1, busy=0, trim_valid=1, sat per REQ-013; the next state SHALL be IDLE.
REQ-021 Latency: done SHALL assert exactly 5*(SETTLE_CYC+1)+1 cycles after the edge that samples start.
REQ-022 start SHALL be ignored while busy=1 and during the DONE cycle.
REQ-023 start held high continuously SHALL retrigger a new search from IDLE one cycle after DONE.
REQ-024 abort=1 in SETTLE or DECIDE SHALL, at the next edge, set trim=DEF_TRIM, clear busy and trim_valid, produce no done pulse, and go to IDLE.
REQ-025 abort=1 in IDLE or DONE SHALL have no effect; abort SHALL win over a simultaneous start.
REQ-026 trim SHALL change only at clock edges, only in the cycles named in REQ-016, REQ-018, REQ-019 and REQ-024, and SHALL hold its value in IDLE.

Reset
REQ-027 With rst_n=0 at an edge, whatever the state, the block SHALL go to IDLE with:
- trim=DEF_TRIM;
- busy, done, trim_valid, sat = 0;
- counter, bit_idx and synchronizer flops = 0.
REQ-028 An in-progress search interrupted by reset SHALL NOT produce a done pulse.

Structure
REQ-029 Package nvt_trim_pkg SHALL hold the FSM state enum, TRIM_W=5, and the MSB-trial constant 5'b10000.
REQ-030 The synchronizer SHALL be a separate sub-module, nvt_sv_sync2 (2-flop, reset value 0), instantiated once.

Verification
The bench uses SETTLE_CYC=4 and a behavioural comparator cmp_out = (trim <= target).
REQ-031 Target 13: start pulse -> final trim=5'b01101, done pulse exactly 26 cycles after the start edge, sat=0, trim_valid=1.
REQ-032 cmp_out forced 1 -> trim=5'b11111, sat=1.
REQ-033 cmp_out forced 0 -> trim=5'b00000, sat=1.
REQ-034 Abort during the third SETTLE -> trim=5'b10000 next cycle, busy=0, no done pulse.
REQ-035 start and abort in the same cycle in IDLE -> no search; start re-pulsed while busy -> ignored, completion time unchanged.
REQ-036 rst_n=0 mid-search -> all outputs at reset values next cycle; a subsequent start completes normally with the correct code.
